// File: rtl/joybus_poll_sched.sv
// JOYBUS host command sequencer: periodic N64/GC poll plus one-shot
// software commands, one byte per host transaction, then a response window.
module joybus_poll_sched #(
    parameter int POLL_PERIOD = 400000,
    parameter int RSP_TIMEOUT = 2400,
    parameter int TX_TIMEOUT  = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       gc_mode,
    input  logic       rumble,
    input  logic       sw_req,
    input  logic [7:0] sw_cmd,
    output logic       sw_ack,
    output logic [7:0] host_cmd_data,
    output logic       host_cmd_rdy,
    input  logic       host_tx_done,
    input  logic       rsp_valid,
    output logic       busy,
    output logic       poll_ok,
    output logic       poll_timeout,
    output logic       poll_overrun
);

    localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TMAX = (RSP_TIMEOUT > TX_TIMEOUT) ? RSP_TIMEOUT : TX_TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PER_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] RSP_LAST = TW'(RSP_TIMEOUT - 1);
    localparam logic [TW-1:0] TX_LAST  = TW'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_TX,
        S_RSP_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_q, per_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    nbytes_q, nbytes_d;
    logic          sw_q, sw_d;
    logic [7:0]    sw_cmd_q, sw_cmd_d;
    logic          gc_q, gc_d;
    logic          rumble_q, rumble_d;
    logic [7:0]    data_q, data_d;

    logic [7:0]    cur_byte;
    logic [1:0]    idx_nxt;
    logic          wrap;

    // Byte idx of the sequence currently being sent.
    always_comb begin
        cur_byte = 8'h01;
        if (sw_q) begin
            cur_byte = sw_cmd_q;
        end else if (gc_q) begin
            case (idx_q)
                2'd0:    cur_byte = 8'h40;
                2'd1:    cur_byte = 8'h03;
                default: cur_byte = {7'b0, rumble_q};
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        pend_d       = pend_q;
        tmr_d        = tmr_q;
        idx_d        = idx_q;
        nbytes_d     = nbytes_q;
        sw_d         = sw_q;
        sw_cmd_d     = sw_cmd_q;
        gc_d         = gc_q;
        rumble_d     = rumble_q;
        data_d       = data_q;
        sw_ack       = 1'b0;
        poll_ok      = 1'b0;
        poll_timeout = 1'b0;
        poll_overrun = 1'b0;
        idx_nxt      = idx_q + 2'd1;

        wrap = enable && (per_q == PER_LAST);
        if (!enable || wrap) begin
            per_d = '0;
        end else begin
            per_d = per_q + 1'b1;
        end
        if (wrap) begin
            pend_d       = 1'b1;
            poll_overrun = pend_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (sw_req) begin
                    sw_ack   = 1'b1;
                    sw_d     = 1'b1;
                    sw_cmd_d = sw_cmd;
                    nbytes_d = 2'd1;
                    idx_d    = 2'd0;
                    state_d  = S_LOAD;
                end else if (pend_q) begin
                    // A wrap in this very cycle re-arms the flag.
                    pend_d   = wrap;
                    sw_d     = 1'b0;
                    gc_d     = gc_mode;
                    rumble_d = rumble;
                    nbytes_d = gc_mode ? 2'd3 : 2'd1;
                    idx_d    = 2'd0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = cur_byte;
                state_d = S_SEND;
            end
            S_SEND: begin
                tmr_d   = '0;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (host_tx_done) begin
                    idx_d = idx_nxt;
                    if (idx_nxt < nbytes_q) begin
                        state_d = S_LOAD;
                    end else begin
                        tmr_d   = '0;
                        state_d = S_RSP_WAIT;
                    end
                end else if (tmr_q == TX_LAST) begin
                    poll_timeout = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RSP_WAIT: begin
                if (rsp_valid) begin
                    poll_ok = 1'b1;
                    state_d = S_IDLE;
                end else if (tmr_q == RSP_LAST) begin
                    poll_timeout = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            sw_ack       = 1'b0;
            poll_ok      = 1'b0;
            poll_timeout = 1'b0;
            poll_overrun = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            per_q    <= '0;
            pend_q   <= 1'b0;
            tmr_q    <= '0;
            idx_q    <= 2'd0;
            nbytes_q <= 2'd0;
            sw_q     <= 1'b0;
            sw_cmd_q <= 8'h00;
            gc_q     <= 1'b0;
            rumble_q <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            pend_q   <= pend_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            nbytes_q <= nbytes_d;
            sw_q     <= sw_d;
            sw_cmd_q <= sw_cmd_d;
            gc_q     <= gc_d;
            rumble_q <= rumble_d;
            data_q   <= data_d;
        end
    end

    assign host_cmd_data = data_q;
    assign host_cmd_rdy  = (state_q == S_SEND);
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_joybus_poll_sched.sv
// Bench for joybus_poll_sched: per-cycle check against a transaction-level
// model, plus directed scenarios with hand-computed timing.
module tb_joybus_poll_sched;

    localparam int P  = 100;
    localparam int RT = 64;
    localparam int TT = 250;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       gc_mode;
    logic       rumble;
    logic       sw_req;
    logic [7:0] sw_cmd;
    logic       sw_ack;
    logic [7:0] host_cmd_data;
    logic       host_cmd_rdy;
    logic       host_tx_done;
    logic       rsp_valid;
    logic       busy;
    logic       poll_ok;
    logic       poll_timeout;
    logic       poll_overrun;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    string lit_name[$];
    int    lit_act[$];
    int    lit_exp[$];

    joybus_poll_sched #(
        .POLL_PERIOD(P),
        .RSP_TIMEOUT(RT),
        .TX_TIMEOUT (TT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .gc_mode      (gc_mode),
        .rumble       (rumble),
        .sw_req       (sw_req),
        .sw_cmd       (sw_cmd),
        .sw_ack       (sw_ack),
        .host_cmd_data(host_cmd_data),
        .host_cmd_rdy (host_cmd_rdy),
        .host_tx_done (host_tx_done),
        .rsp_valid    (rsp_valid),
        .busy         (busy),
        .poll_ok      (poll_ok),
        .poll_timeout (poll_timeout),
        .poll_overrun (poll_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: a queue of bytes still to send and timestamps of the last
    // cmd_rdy / tx_done; timeouts are plain cycle differences.
    int         m_cnt;
    bit         m_pend;
    bit         m_busy;
    bit         m_txw;
    bit         m_rspw;
    logic [7:0] m_q[$];
    logic [7:0] m_data;
    int         m_rdy_at;
    int         m_t_rdy;
    int         m_t_done;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit e_ack, e_rdy, e_ok, e_to, e_ovr, e_busy, wrap, take;
        while (lit_act.size() > 0)
            chk(lit_name.pop_front(), lit_act.pop_front(), lit_exp.pop_front());
        if (rst) begin
            m_cnt    = 0;
            m_pend   = 0;
            m_busy   = 0;
            m_txw    = 0;
            m_rspw   = 0;
            m_data   = 8'h00;
            m_rdy_at = -1;
            m_q.delete();
        end else begin
            e_ack  = 0;
            e_rdy  = 0;
            e_ok   = 0;
            e_to   = 0;
            take   = 0;
            e_busy = m_busy;
            wrap   = enable && (m_cnt == P - 1);
            e_ovr  = wrap && m_pend;
            if (!m_busy) begin
                if (sw_req) begin
                    e_ack = 1;
                    m_q.delete();
                    m_q.push_back(sw_cmd);
                    m_busy = 1;
                end else if (m_pend) begin
                    take = 1;
                    m_q.delete();
                    if (gc_mode) begin
                        m_q.push_back(8'h40);
                        m_q.push_back(8'h03);
                        m_q.push_back({7'b0, rumble});
                    end else begin
                        m_q.push_back(8'h01);
                    end
                    m_busy = 1;
                end
                if (m_busy) begin
                    m_rdy_at = cyc + 2;
                    m_txw    = 0;
                    m_rspw   = 0;
                end
            end else if (cyc == m_rdy_at) begin
                e_rdy   = 1;
                m_data  = m_q.pop_front();
                m_txw   = 1;
                m_t_rdy = cyc;
            end else if (m_txw) begin
                if (host_tx_done) begin
                    m_txw = 0;
                    if (m_q.size() != 0) begin
                        m_rdy_at = cyc + 2;
                    end else begin
                        m_rspw   = 1;
                        m_t_done = cyc;
                    end
                end else if (cyc - m_t_rdy == TT) begin
                    e_to   = 1;
                    m_busy = 0;
                    m_txw  = 0;
                    m_q.delete();
                end
            end else if (m_rspw) begin
                if (rsp_valid) begin
                    e_ok   = 1;
                    m_busy = 0;
                    m_rspw = 0;
                end else if (cyc - m_t_done == RT) begin
                    e_to   = 1;
                    m_busy = 0;
                    m_rspw = 0;
                end
            end
            chk("sw_ack", sw_ack, e_ack);
            chk("host_cmd_rdy", host_cmd_rdy, e_rdy);
            chk("host_cmd_data", host_cmd_data, m_data);
            chk("busy", busy, e_busy);
            chk("poll_ok", poll_ok, e_ok);
            chk("poll_timeout", poll_timeout, e_to);
            chk("poll_overrun", poll_overrun, e_ovr);
            m_cnt  = (!enable || wrap) ? 0 : m_cnt + 1;
            m_pend = wrap ? 1'b1 : (take ? 1'b0 : m_pend);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        lit_name.push_back(nm);
        lit_act.push_back(act);
        lit_exp.push_back(exp);
    endtask

    task automatic do_reset();
        rst          = 1;
        enable       = 0;
        gc_mode      = 0;
        rumble       = 0;
        sw_req       = 0;
        sw_cmd       = 8'h00;
        host_tx_done = 0;
        rsp_valid    = 0;
        step(2);
        rst = 0;
    endtask

    task automatic wait_rdy(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (host_cmd_rdy) begin
                at = cyc;
                break;
            end
            step(1);
        end
        if (at < 0) lit("wait_rdy_expired", 0, 1);
    endtask

    task automatic wait_to(input int budget, output int at, output int ovr);
        at  = -1;
        ovr = -1;
        for (int i = 0; i < budget; i++) begin
            if (poll_overrun) ovr = cyc;
            if (poll_timeout) begin
                at = cyc;
                break;
            end
            step(1);
        end
        if (at < 0) lit("wait_timeout_expired", 0, 1);
    endtask

    task automatic pulse_tx(output int at);
        host_tx_done = 1;
        at           = cyc;
        step(1);
        host_tx_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int         e, t, t2, td, k, r, ovr, n;
        logic [7:0] gcb[3];
        gcb[0] = 8'h40;
        gcb[1] = 8'h03;
        gcb[2] = 8'h01;

        // N64 poll; enable dropped mid-sequence
        do_reset();
        lit("rst_busy", busy, 0);
        lit("rst_data", host_cmd_data, 0);
        lit("rst_rdy", host_cmd_rdy, 0);
        enable = 1;
        e      = cyc;
        wait_rdy(150, t);
        lit("n64_lat", t - e, 102);
        lit("n64_data", host_cmd_data, 8'h01);
        enable = 0;
        step(5);
        pulse_tx(td);
        step(49);
        rsp_valid = 1;
        #1;
        lit("n64_ok", poll_ok, 1);
        step(1);
        rsp_valid = 0;
        lit("n64_busy_drop", busy, 0);
        n = 0;
        repeat (250) begin
            if (host_cmd_rdy) n++;
            step(1);
        end
        lit("no_poll_disabled", n, 0);

        // GC poll with rumble; mode inputs change mid-sequence
        do_reset();
        enable  = 1;
        gc_mode = 1;
        rumble  = 1;
        e       = cyc;
        td      = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rdy(150, t);
            lit($sformatf("gc_byte%0d", i), host_cmd_data, gcb[i]);
            if (i == 0) begin
                lit("gc_lat", t - e, 102);
                gc_mode = 0;
                rumble  = 0;
            end else begin
                lit($sformatf("gc_gap%0d", i), t - td, 2);
            end
            step(3 + i);
            pulse_tx(td);
        end
        step(9);
        rsp_valid = 1;
        #1;
        lit("gc_ok", poll_ok, 1);
        step(1);
        rsp_valid = 0;

        // Response timeout, TX watchdog with overrun, reset mid WAIT_TX
        do_reset();
        enable = 1;
        e      = cyc;
        wait_rdy(150, t);
        step(4);
        pulse_tx(td);
        wait_to(100, t, ovr);
        lit("rsp_timeout_dly", t - td, RT);
        step(1);
        lit("rsp_timeout_idle", busy, 0);
        wait_rdy(150, t2);
        wait_to(300, t, ovr);
        lit("tx_timeout_dly", t - t2, TT);
        lit("overrun_cyc", ovr - e, 399);
        step(1);
        lit("tx_timeout_idle", busy, 0);
        wait_rdy(10, t);
        step(3);
        rst = 1;
        step(1);
        rst = 0;
        r   = cyc;
        #1;
        lit("rst_mid_busy", busy, 0);
        lit("rst_mid_data", host_cmd_data, 0);
        lit("rst_mid_rdy", host_cmd_rdy, 0);
        wait_rdy(150, t);
        lit("post_rst_lat", t - r, 102);

        // Software command ties with a pending poll
        do_reset();
        enable = 1;
        e      = cyc;
        while (cyc < e + 100) step(1);
        sw_req = 1;
        sw_cmd = 8'hFF;
        #1;
        lit("arb_ack", sw_ack, 1);
        step(1);
        sw_req = 0;
        wait_rdy(10, t);
        lit("arb_sw_data", host_cmd_data, 8'hFF);
        lit("arb_sw_lat", t - e, 102);
        step(2);
        pulse_tx(td);
        step(5);
        rsp_valid = 1;
        k         = cyc;
        step(1);
        rsp_valid = 0;
        wait_rdy(10, t);
        lit("arb_poll_data", host_cmd_data, 8'h01);
        lit("arb_poll_lat", t - k, 3);
        step(2);
        pulse_tx(td);
        step(3);
        rsp_valid = 1;
        step(1);
        rsp_valid = 0;
        step(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
